// File: rtl/line_draw_sequencer_if.sv
// line_draw_sequencer_if: line request and pixel stream bundle for the line sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline's view.
interface line_draw_sequencer_if #(
  parameter int WIDTH = 13
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic             pix_valid;
  logic             pix_ready;
  logic [WIDTH-1:0] pix_x;
  logic [WIDTH-1:0] pix_y;
  logic             pix_last;
  logic             busy;
  logic             done;

  modport master (
    output req_valid, x0, y0, x1, y1, pix_ready,
    input  req_ready, pix_valid, pix_x, pix_y, pix_last, busy, done
  );

  modport slave (
    input  req_valid, x0, y0, x1, y1, pix_ready,
    output req_ready, pix_valid, pix_x, pix_y, pix_last, busy, done
  );
endinterface

// File: rtl/line_draw_sequencer.sv
// line_draw_sequencer: Bresenham setup and per-pixel stepping with valid/ready pixel output.
// Define LINE_SEQ_ABORT_EN to add an abort input that drops the line in SETUP1/SETUP2/DRAW.
//
// state  | meaning
// IDLE   | waiting for a line request, req_ready high
// SETUP1 | steep detect, swap x/y of both endpoints when steep
// SETUP2 | order endpoints along x, compute deltas, ystep, initial error
// DRAW   | present one pixel per handshake until x reaches x_end
// DONE   | one-cycle done pulse
module line_draw_sequencer #(
  parameter int WIDTH = 13
) (
  input  logic clk,
  input  logic rst,
`ifdef LINE_SEQ_ABORT_EN
  input  logic abort,
`endif
  line_draw_sequencer_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP1 = 3'd1;
  localparam logic [2:0] ST_SETUP2 = 3'd2;
  localparam logic [2:0] ST_DRAW   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [WIDTH-1:0]        x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic                    steep_q, steep_d;
  logic                    ystep_neg_q, ystep_neg_d;
  logic signed [WIDTH:0]   deltax_q, deltax_d, deltay_q, deltay_d;
  logic signed [WIDTH:0]   error_q, error_d;
  logic [WIDTH-1:0]        x_q, x_d, y_q, y_d, x_end_q, x_end_d;

  logic                    abort_hit;
  logic                    ep_swap;
  logic [WIDTH-1:0]        sx0, sy0, sx1, sy1;
  logic signed [WIDTH:0]   s1_adx, s1_ady, s2_dx, s2_dy, e_next;
  logic                    at_end;

  // Differences are taken one bit wider than the coordinates so they never overflow.
  function automatic logic signed [WIDTH:0] sext(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], v};
  endfunction

  function automatic logic signed [WIDTH:0] absv(input logic signed [WIDTH:0] v);
    return v[WIDTH] ? -v : v;
  endfunction

`ifdef LINE_SEQ_ABORT_EN
  assign abort_hit = abort && (state_q == ST_SETUP1 || state_q == ST_SETUP2 ||
                               state_q == ST_DRAW);
`else
  assign abort_hit = 1'b0;
`endif

  assign s1_adx  = absv(sext(x1_q) - sext(x0_q));
  assign s1_ady  = absv(sext(y1_q) - sext(y0_q));
  assign ep_swap = $signed(x0_q) > $signed(x1_q);
  assign sx0     = ep_swap ? x1_q : x0_q;
  assign sy0     = ep_swap ? y1_q : y0_q;
  assign sx1     = ep_swap ? x0_q : x1_q;
  assign sy1     = ep_swap ? y0_q : y1_q;
  assign s2_dx   = sext(sx1) - sext(sx0);
  assign s2_dy   = sext(sy1) - sext(sy0);
  assign e_next  = error_q - deltay_q;
  assign at_end  = (x_q == x_end_q);

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    steep_d     = steep_q;
    ystep_neg_d = ystep_neg_q;
    deltax_d    = deltax_q;
    deltay_d    = deltay_q;
    error_d     = error_q;
    x_d         = x_q;
    y_d         = y_q;
    x_end_d     = x_end_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          x0_d    = bus.x0;
          y0_d    = bus.y0;
          x1_d    = bus.x1;
          y1_d    = bus.y1;
          state_d = ST_SETUP1;
        end
      end
      ST_SETUP1: begin
        steep_d = s1_ady > s1_adx;
        if (s1_ady > s1_adx) begin
          x0_d = y0_q;
          y0_d = x0_q;
          x1_d = y1_q;
          y1_d = x1_q;
        end
        state_d = ST_SETUP2;
      end
      ST_SETUP2: begin
        deltax_d    = s2_dx;
        deltay_d    = absv(s2_dy);
        ystep_neg_d = !($signed(sy0) < $signed(sy1));
        error_d     = s2_dx >>> 1;
        x_d         = sx0;
        y_d         = sy0;
        x_end_d     = sx1;
        state_d     = ST_DRAW;
      end
      ST_DRAW: begin
        if (bus.pix_ready) begin
          if (at_end) begin
            state_d = ST_DONE;
          end else begin
            x_d = x_q + WIDTH'(1);
            if (e_next[WIDTH]) begin
              y_d     = ystep_neg_q ? (y_q - WIDTH'(1)) : (y_q + WIDTH'(1));
              error_d = e_next + deltax_q;
            end else begin
              error_d = e_next;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      steep_q     <= 1'b0;
      ystep_neg_q <= 1'b0;
      deltax_q    <= '0;
      deltay_q    <= '0;
      error_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      x_end_q     <= '0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      steep_q     <= steep_d;
      ystep_neg_q <= ystep_neg_d;
      deltax_q    <= deltax_d;
      deltay_q    <= deltay_d;
      error_q     <= error_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x_end_q     <= x_end_d;
    end
  end

  // Pixel outputs come straight from the registered datapath, so a stall holds them.
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pix_valid = (state_q == ST_DRAW);
  assign bus.pix_x     = steep_q ? y_q : x_q;
  assign bus.pix_y     = steep_q ? x_q : y_q;
  assign bus.pix_last  = (state_q == ST_DRAW) && at_end;

endmodule

// File: tb/tb_line_draw_sequencer.sv
// tb_line_draw_sequencer: directed lines with hand-computed Bresenham pixel lists.
// Covers ordering, swaps, negative ystep, backpressure, degenerate lines and mid-line reset.
module tb_line_draw_sequencer;
  localparam int W = 13;

  logic clk = 1'b0;
  logic rst = 1'b0;
`ifdef LINE_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif

  line_draw_sequencer_if #(.WIDTH(W)) bus ();

  line_draw_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef LINE_SEQ_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_x[$];
  int exp_y[$];

  task automatic check_val(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // Runs one line; all sampling at negedge, so a handshake is pix_valid & pix_ready seen here.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int stall_idx, input int stall_len,
                          input bit poke, input int rst_after);
    int hs = 0;
    int k = 1;
    int first_k = -1;
    int last_k = -1;
    int done_k = -1;
    int n_done = 0;
    int stall_left = stall_len;
    bit fin = 1'b0;
    bit poke_on = 1'b0;
    @(negedge clk);
    check_val("req_ready_idle", bus.req_ready, 1);
    bus.x0 = W'(ax0);
    bus.y0 = W'(ay0);
    bus.x1 = W'(ax1);
    bus.y1 = W'(ay1);
    bus.req_valid = 1'b1;
    bus.pix_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_val("busy_setup", bus.busy, 1);
    check_val("req_ready_setup", bus.req_ready, 0);
    while (!fin && k < 200) begin
      if (poke_on && k > first_k) begin
        bus.req_valid = 1'b0;
        poke_on = 1'b0;
      end
      if (bus.done) begin
        n_done++;
        done_k = k;
        fin = 1'b1;
      end else if (bus.pix_valid) begin
        if (first_k < 0) begin
          first_k = k;
          if (poke) begin
            bus.x0 = W'(100);
            bus.x1 = W'(200);
            bus.req_valid = 1'b1;
            poke_on = 1'b1;
            check_val("req_ready_draw", bus.req_ready, 0);
          end
        end
        if (rst_after >= 0 && hs == rst_after) begin
          rst = 1'b0;
          fin = 1'b1;
        end else if (hs == stall_idx && stall_left > 0) begin
          bus.pix_ready = 1'b0;
          stall_left--;
          check_val("stall_x", sx(bus.pix_x), exp_x[hs]);
          check_val("stall_y", sx(bus.pix_y), exp_y[hs]);
          check_val("stall_last", bus.pix_last, 0);
        end else begin
          bus.pix_ready = 1'b1;
          if (hs < exp_x.size()) begin
            check_val("pix_x", sx(bus.pix_x), exp_x[hs]);
            check_val("pix_y", sx(bus.pix_y), exp_y[hs]);
            check_val("pix_last", bus.pix_last, int'(hs == exp_x.size() - 1));
          end
          if (bus.pix_last) last_k = k;
          hs++;
        end
      end
      if (!fin) begin
        @(negedge clk);
        k++;
      end
    end
    if (rst_after < 0) begin
      check_val("done_seen", n_done, 1);
      check_val("pix_count", hs, exp_x.size());
      check_val("first_latency", first_k, 3);
      check_val("done_after_last", done_k - last_k, 1);
      @(negedge clk);
      check_val("done_pulse_end", bus.done, 0);
      check_val("req_ready_back", bus.req_ready, 1);
      check_val("busy_idle", bus.busy, 0);
      if (poke) begin
        @(negedge clk);
        check_val("no_queued_req", bus.busy, 0);
      end
    end else begin
      check_val("pix_before_rst", hs, rst_after);
      @(negedge clk);
      check_val("rst_pix_valid", bus.pix_valid, 0);
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_done", bus.done, 0);
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_req_ready", bus.req_ready, 1);
      check_val("rst_no_done", bus.done, 0);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.pix_ready = 1'b1;
    bus.x0 = '0;
    bus.y0 = '0;
    bus.x1 = '0;
    bus.y1 = '0;
    repeat (3) @(negedge clk);
    check_val("reset_pix_valid", bus.pix_valid, 0);
    check_val("reset_busy", bus.busy, 0);
    check_val("reset_done", bus.done, 0);
    check_val("reset_pix_last", bus.pix_last, 0);
    check_val("reset_pix_x", sx(bus.pix_x), 0);
    check_val("reset_pix_y", sx(bus.pix_y), 0);
    rst = 1'b1;
    @(negedge clk);
    check_val("release_req_ready", bus.req_ready, 1);

    exp_x = '{0, 1, 2, 3, 4, 5};
    exp_y = '{0, 0, 1, 1, 2, 2};
    run_line(0, 0, 5, 2, -1, 0, 1'b0, -1);

    exp_x = '{0, 0, 1, 1, 2, 2};
    exp_y = '{0, 1, 2, 3, 4, 5};
    run_line(2, 5, 0, 0, -1, 0, 1'b0, -1);

    exp_x = '{0, 1, 2, 3};
    exp_y = '{3, 2, 1, 0};
    run_line(0, 3, 3, 0, -1, 0, 1'b0, -1);

    exp_x = '{0, 1, 2, 3, 4, 5};
    exp_y = '{0, 0, 1, 1, 2, 2};
    run_line(0, 0, 5, 2, 1, 4, 1'b0, -1);

    exp_x = '{7};
    exp_y = '{7};
    run_line(7, 7, 7, 7, -1, 0, 1'b1, -1);

    exp_x = '{0, 1, 2, 3, 4, 5};
    exp_y = '{0, 0, 1, 1, 2, 2};
    run_line(0, 0, 5, 2, -1, 0, 1'b0, 2);
    run_line(0, 0, 5, 2, -1, 0, 1'b0, -1);

    exp_x = '{-2, -2, -1, -1, 0};
    exp_y = '{-4, -3, -2, -1, 0};
    run_line(0, 0, -2, -4, -1, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/line_draw_sequencer.md
Name: line_draw_sequencer

Overview:
Top-level sequencer for one line-drawing core: accepts a line request (two endpoints), performs Bresenham setup (steep detect, axis swap, endpoint swap, deltas, ystep, initial error), then steps x and the error term one pixel per accepted handshake. It emits a pixel stream with valid/ready backpressure to the raster/framebuffer writer. It sits between the primitive-assembly stage and the framebuffer write path, replacing ad-hoc start/last_count sequencing of the counter and error datapath.

Parameters:
WIDTH, 13, coordinate width; signed two's complement for all coordinate arithmetic.

Ports:
clk  input  1  clock; all logic rising-edge.
rst  input  1  reset, synchronous, active-low.
req_valid  input  1  line request present.
req_ready  output  1  sequencer can accept a request; high only in IDLE.
x0  input  WIDTH  start x, sampled on req handshake.
y0  input  WIDTH  start y, sampled on req handshake.
x1  input  WIDTH  end x, sampled on req handshake.
y1  input  WIDTH  end y, sampled on req handshake.
pix_valid  output  1  pix_x/pix_y hold a valid pixel.
pix_ready  input  1  downstream accepts pixel.
pix_x  output  WIDTH  pixel x in original (unswapped) space.
pix_y  output  WIDTH  pixel y in original space.
pix_last  output  1  current pixel is the final pixel of the line.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; pix_valid, pix_last, done, busy = 0; pix_x, pix_y, and all internal registers = 0; req_ready = 1 from the first cycle after release. Reset mid-line abandons the line immediately with no done pulse.
- States: IDLE -> SETUP1 -> SETUP2 -> DRAW -> DONE -> IDLE.
- IDLE: on req_valid & req_ready, latch endpoints and go to SETUP1.
- SETUP1: steep = |y1-y0| > |x1-x0|. If steep, swap x with y for both endpoints.
- SETUP2: if x0 > x1 (signed), swap the endpoints. Compute:
  - deltax = x1-x0 (>=0)
  - deltay = |y1-y0|
  - ystep = +1 if y0 < y1, else -1
  - error = deltax >>> 1
  - x = x0, y = y0, x_end = x1
- Width rules: differences and error are held in WIDTH+1 signed bits, so no overflow occurs for any WIDTH-bit inputs. x, y, and outputs are WIDTH bits.
- DRAW:
  - pix_valid = 1; pix_x/pix_y = (y,x) if steep, else (x,y); pix_last = (x == x_end).
  - While pix_valid & !pix_ready, all outputs and the datapath are held stable. No pixel is dropped or repeated.
  - On handshake with pix_last = 1: go to DONE.
  - On handshake otherwise: x <= x+1; e' = error - deltay; if e' < 0 then y <= y+ystep and error <= e'+deltax, else error <= e'.
- DONE: pix_valid = 0, done = 1 for exactly one cycle, then IDLE.
- Latency: request accepted at cycle N gives the first pix_valid at N+3. Peak throughput is 1 pixel/cycle. Pixel count = max(|dx|,|dy|)+1. req_ready returns high the cycle after DONE.
- Degenerate line (x0==x1, y0==y1): exactly one pixel with pix_last = 1.
- Pixel order: always ascending along the major axis after the swap, which may reverse the drawing direction relative to the request.
- req_valid outside IDLE is ignored; no request is queued.

Optional Feature:
LINE_SEQ_ABORT_EN: when defined, adds input `abort` (1 bit).
- abort = 1 in SETUP1, SETUP2 or DRAW forces IDLE at the next posedge. pix_valid drops that edge, with no done pulse and no further pixels. abort is ignored in IDLE and DONE.
- When undefined, the port does not exist and lines always run to completion.

Test Plan:
1. (0,0)->(5,2), pix_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2); pix_last only on (5,2); first pix_valid 3 cycles after accept; done 1 cycle after last.
2. Steep and reversed, (2,5)->(0,0) -> pixels (0,0),(0,1),(1,2),(1,3),(2,4),(2,5) in that order.
3. Negative ystep, (0,3)->(3,0) -> pixels (0,3),(1,2),(2,1),(3,0), using ystep = -1.
4. Backpressure: line 1 with pix_ready=0 for 4 cycles while (1,0) is presented -> (1,0) held stable; the sequence is identical to test 1 and contains exactly 6 pixels.
5. Degenerate (7,7)->(7,7) -> a single pixel (7,7) with pix_last=1, then done; req_valid asserted during DRAW is ignored (req_ready=0).
6. rst=0 during DRAW of line 1 after 2 pixels -> next edge pix_valid=0, busy=0, no done; after release req_ready=1 and a new line (0,0)->(5,2) draws correctly.
